// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter_if
//  Description : Fetch, data and memory-bus signal bundle for mem_port_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int XLEN = 32
);
    logic            if_req_valid;
    logic [XLEN-1:0] if_addr;
    logic            if_req_ready;
    logic            if_flush;
    logic            if_rsp_valid;
    logic [XLEN-1:0] if_rdata;
    logic            if_rsp_err;

    logic            d_req_valid;
    logic            d_we;
    logic [XLEN-1:0] d_addr;
    logic [XLEN-1:0] d_wdata;
    logic [3:0]      d_wstrb;
    logic            d_req_ready;
    logic            d_rsp_valid;
    logic [XLEN-1:0] d_rdata;
    logic            d_rsp_err;

    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [3:0]      mem_wstrb;
    logic            mem_ack;
    logic [XLEN-1:0] mem_rdata;

    // Arbiter side.
    modport slave (
        input  if_req_valid, if_addr, if_flush,
        input  d_req_valid, d_we, d_addr, d_wdata, d_wstrb,
        input  mem_ack, mem_rdata,
        output if_req_ready, if_rsp_valid, if_rdata, if_rsp_err,
        output d_req_ready, d_rsp_valid, d_rdata, d_rsp_err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

    // Requester / memory side.
    modport master (
        output if_req_valid, if_addr, if_flush,
        output d_req_valid, d_we, d_addr, d_wdata, d_wstrb,
        output mem_ack, mem_rdata,
        input  if_req_ready, if_rsp_valid, if_rdata, if_rsp_err,
        input  d_req_ready, d_rsp_valid, d_rdata, d_rsp_err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one variable-latency memory port between fetch and
//                data requesters; data priority, fetch anti-starvation,
//                watchdog timeout and fetch squash on PC redirect.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int XLEN        = 32,
    parameter int STARVE_MAX  = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  wire logic           clk,
    input  wire logic           rst,
    mem_port_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BUSY_I = 2'd1,
        S_BUSY_D = 2'd2
    } state_t;

    localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_MAX);
    localparam logic [7:0] c_TMO_LAST   = 8'(TIMEOUT_CYC - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [3:0]      r_starve;
    logic [7:0]      r_timer;
    logic            r_squash;

    logic            w_fetch_ok;
    logic            w_grant_i;
    logic            w_grant_d;
    logic            w_done;
    logic [XLEN-1:0] w_rsp_data;

    // Completion: ack has priority over the watchdog in the same cycle.
    always_comb begin
        w_state_nxt      = r_state;
        w_grant_i        = 1'b0;
        w_grant_d        = 1'b0;
        w_done           = 1'b0;
        w_fetch_ok       = bus.if_req_valid && !bus.if_flush;
        w_rsp_data       = bus.mem_ack ? bus.mem_rdata : '0;
        case (r_state)
            S_IDLE: begin
                if (w_fetch_ok && (!bus.d_req_valid || r_starve == c_STARVE_MAX)) begin
                    w_grant_i   = 1'b1;
                    w_state_nxt = S_BUSY_I;
                end else if (bus.d_req_valid) begin
                    w_grant_d   = 1'b1;
                    w_state_nxt = S_BUSY_D;
                end
            end
            S_BUSY_I, S_BUSY_D: begin
                if (bus.mem_ack || r_timer == c_TMO_LAST) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        bus.if_req_ready = w_grant_i;
        bus.d_req_ready  = w_grant_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_starve         <= '0;
            r_timer          <= '0;
            r_squash         <= 1'b0;
            bus.mem_req      <= 1'b0;
            bus.mem_we       <= 1'b0;
            bus.mem_addr     <= '0;
            bus.mem_wdata    <= '0;
            bus.mem_wstrb    <= '0;
            bus.if_rsp_valid <= 1'b0;
            bus.if_rdata     <= '0;
            bus.if_rsp_err   <= 1'b0;
            bus.d_rsp_valid  <= 1'b0;
            bus.d_rdata      <= '0;
            bus.d_rsp_err    <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            bus.if_rsp_valid <= 1'b0;
            bus.if_rsp_err   <= 1'b0;
            bus.d_rsp_valid  <= 1'b0;
            bus.d_rsp_err    <= 1'b0;

            if (w_grant_i) begin
                r_starve <= '0;
            end else if (w_grant_d && w_fetch_ok && r_starve != c_STARVE_MAX) begin
                r_starve <= r_starve + 4'd1;
            end

            if (w_grant_i || w_grant_d) begin
                bus.mem_req   <= 1'b1;
                bus.mem_we    <= w_grant_d && bus.d_we;
                bus.mem_addr  <= w_grant_d ? bus.d_addr : bus.if_addr;
                bus.mem_wdata <= w_grant_d ? bus.d_wdata : '0;
                bus.mem_wstrb <= (w_grant_d && bus.d_we) ? bus.d_wstrb : 4'h0;
                r_timer       <= '0;
                r_squash      <= 1'b0;
            end else if (w_done) begin
                bus.mem_req <= 1'b0;
                r_squash    <= 1'b0;
                if (r_state == S_BUSY_I) begin
                    // A redirect seen at any point of the fetch, including now, drops it.
                    if (!(r_squash || bus.if_flush)) begin
                        bus.if_rsp_valid <= 1'b1;
                        bus.if_rdata     <= w_rsp_data;
                        bus.if_rsp_err   <= !bus.mem_ack;
                    end
                end else begin
                    bus.d_rsp_valid <= 1'b1;
                    bus.d_rdata     <= bus.mem_we ? '0 : w_rsp_data;
                    bus.d_rsp_err   <= !bus.mem_ack;
                end
            end else if (r_state != S_IDLE) begin
                r_timer <= r_timer + 8'd1;
                if (r_state == S_BUSY_I && bus.if_flush) begin
                    r_squash <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Directed self-checking bench for mem_port_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    mem_port_arbiter_if #(.XLEN(32)) bus ();

    mem_port_arbiter #(
        .XLEN        (32),
        .STARVE_MAX  (4),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  cnt;
        logic exp_i;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.if_req_valid = 1'b0; bus.if_addr = '0; bus.if_flush = 1'b0;
        bus.d_req_valid  = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0;
        bus.d_wdata = '0; bus.d_wstrb = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;

        // Reset state
        tick(); tick();
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_if_rsp", bus.if_rsp_valid, 0);
        chk("rst_d_rsp", bus.d_rsp_valid, 0);
        rst = 1'b0;
        tick();

        // Single fetch, ack two cycles after mem_req rises
        bus.if_req_valid = 1'b1; bus.if_addr = 32'h10;
        #1 chk("f_ready", bus.if_req_ready, 1);
        tick(); bus.if_req_valid = 1'b0;
        chk("f_req_t1", bus.mem_req, 1);
        chk("f_addr", bus.mem_addr, 32'h10);
        chk("f_we", bus.mem_we, 0);
        chk("f_wstrb", bus.mem_wstrb, 0);
        tick();
        chk("f_req_t2", bus.mem_req, 1);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0050_0093;
        tick(); bus.mem_ack = 1'b0;
        chk("f_rsp", bus.if_rsp_valid, 1);
        chk("f_rdata", bus.if_rdata, 32'h0050_0093);
        chk("f_err", bus.if_rsp_err, 0);
        chk("f_req_off", bus.mem_req, 0);
        tick();
        chk("f_rsp_pulse", bus.if_rsp_valid, 0);
        chk("f_rdata_hold", bus.if_rdata, 32'h0050_0093);

        // Contention: expect D,D,D,D,I,D,D,D,D,I
        bus.if_req_valid = 1'b1; bus.if_addr = 32'h200;
        bus.d_req_valid = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h100; bus.d_wstrb = 4'h0;
        for (int g = 0; g < 10; g++) begin
            exp_i = (g % 5 == 4);
            #1;
            chk($sformatf("c_iready_%0d", g), bus.if_req_ready, exp_i);
            chk($sformatf("c_dready_%0d", g), bus.d_req_ready, !exp_i);
            tick();
            chk($sformatf("c_addr_%0d", g), bus.mem_addr, exp_i ? 32'h200 : 32'h100);
            bus.mem_ack = 1'b1; bus.mem_rdata = 32'hC000_0000 + g;
            tick(); bus.mem_ack = 1'b0;
            if (exp_i) begin
                chk($sformatf("c_irsp_%0d", g), bus.if_rsp_valid, 1);
                chk($sformatf("c_irdata_%0d", g), bus.if_rdata, 32'hC000_0000 + g);
            end else begin
                chk($sformatf("c_drsp_%0d", g), bus.d_rsp_valid, 1);
                chk($sformatf("c_drdata_%0d", g), bus.d_rdata, 32'hC000_0000 + g);
            end
        end
        bus.if_req_valid = 1'b0; bus.d_req_valid = 1'b0;
        tick();

        // Timeout: no ack, mem_req high exactly 8 cycles
        bus.d_req_valid = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h80;
        #1 chk("t_ready", bus.d_req_ready, 1);
        tick(); bus.d_req_valid = 1'b0;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (!bus.mem_req) break;
            cnt++;
            tick();
        end
        chk("t_req_cycles", cnt, 8);
        chk("t_rsp", bus.d_rsp_valid, 1);
        chk("t_err", bus.d_rsp_err, 1);
        chk("t_rdata", bus.d_rdata, 0);
        tick();
        chk("t_rsp_pulse", bus.d_rsp_valid, 0);
        chk("t_err_pulse", bus.d_rsp_err, 0);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
        tick(); bus.mem_ack = 1'b0;
        chk("t_spur_d", bus.d_rsp_valid, 0);
        chk("t_spur_i", bus.if_rsp_valid, 0);
        chk("t_spur_req", bus.mem_req, 0);
        tick();

        // Plain load
        bus.d_req_valid = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h44;
        #1 chk("l_ready", bus.d_req_ready, 1);
        tick(); bus.d_req_valid = 1'b0;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0BAD_F00D;
        tick(); bus.mem_ack = 1'b0;
        chk("l_rsp", bus.d_rsp_valid, 1);
        chk("l_rdata", bus.d_rdata, 32'h0BAD_F00D);
        tick();

        // Store with payload held across a slow ack
        bus.d_req_valid = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h40;
        bus.d_wdata = 32'hDEAD_BEEF; bus.d_wstrb = 4'b0011;
        #1 chk("s_ready", bus.d_req_ready, 1);
        tick();
        bus.d_req_valid = 1'b0; bus.d_we = 1'b0; bus.d_wdata = '0; bus.d_wstrb = '0;
        chk("s_we", bus.mem_we, 1);
        chk("s_wstrb", bus.mem_wstrb, 4'b0011);
        chk("s_addr", bus.mem_addr, 32'h40);
        tick(); tick();
        chk("s_wdata_hold", bus.mem_wdata, 32'hDEAD_BEEF);
        chk("s_req_hold", bus.mem_req, 1);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hAAAA_5555;
        tick(); bus.mem_ack = 1'b0;
        chk("s_rsp", bus.d_rsp_valid, 1);
        chk("s_rdata", bus.d_rdata, 0);
        chk("s_err", bus.d_rsp_err, 0);
        tick();

        // Flush during BUSY_I squashes the response
        bus.if_req_valid = 1'b1; bus.if_addr = 32'h300;
        #1 chk("fl_ready", bus.if_req_ready, 1);
        tick(); bus.if_req_valid = 1'b0; bus.if_flush = 1'b1;
        tick(); bus.if_flush = 1'b0;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1234_5678;
        tick(); bus.mem_ack = 1'b0;
        chk("fl_no_rsp", bus.if_rsp_valid, 0);
        chk("fl_rdata_hold", bus.if_rdata, 32'hC000_0009);
        chk("fl_idle", bus.mem_req, 0);
        // Flush in IDLE blocks the fetch grant
        bus.if_req_valid = 1'b1; bus.if_addr = 32'h304; bus.if_flush = 1'b1;
        #1 chk("fl_idle_block", bus.if_req_ready, 0);
        tick();
        chk("fl_no_accept", bus.mem_req, 0);
        bus.if_flush = 1'b0;
        #1 chk("fl_unblock", bus.if_req_ready, 1);
        tick(); bus.if_req_valid = 1'b0;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1357_9BDF;
        tick(); bus.mem_ack = 1'b0;
        chk("fl_after_rsp", bus.if_rsp_valid, 1);
        chk("fl_after_rdata", bus.if_rdata, 32'h1357_9BDF);
        tick();

        // Reset while BUSY_D abandons the store
        bus.d_req_valid = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h60;
        bus.d_wdata = 32'h55AA_55AA; bus.d_wstrb = 4'hF;
        #1 chk("r_ready", bus.d_req_ready, 1);
        tick(); bus.d_req_valid = 1'b0; bus.d_we = 1'b0;
        chk("r_busy", bus.mem_req, 1);
        rst = 1'b1; bus.mem_ack = 1'b1; bus.mem_rdata = 32'h77;
        tick();
        chk("r_mem_req", bus.mem_req, 0);
        chk("r_mem_we", bus.mem_we, 0);
        chk("r_mem_addr", bus.mem_addr, 0);
        chk("r_mem_wdata", bus.mem_wdata, 0);
        chk("r_mem_wstrb", bus.mem_wstrb, 0);
        chk("r_d_rsp", bus.d_rsp_valid, 0);
        chk("r_if_rdata", bus.if_rdata, 0);
        chk("r_d_err", bus.d_rsp_err, 0);
        rst = 1'b0;
        tick(); bus.mem_ack = 1'b0;
        chk("r_idle_ack_d", bus.d_rsp_valid, 0);
        tick();
        chk("r_idle_ack_d2", bus.d_rsp_valid, 0);
        chk("r_idle_ack_i", bus.if_rsp_valid, 0);
        chk("r_idle_req", bus.mem_req, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
